// File: rtl/vreg_write_arbiter_if.sv
// Request and bank-write bus between vector producers and the register bank write arbiter.
// The arbiter sits on the slave modport; producers and the bank model sit on the master side.
interface vreg_write_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int NREGS = 8,
    parameter int LANES = 16,
    parameter int DW    = 32
);
    localparam int DEST_W = $clog2(NREGS);

    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*DEST_W-1:0]   req_dest;
    logic [NREQ*LANES*DW-1:0] req_data;
    logic [NREQ*LANES-1:0]    req_mask;
    logic                     wr_stall;
    logic                     wr_valid;
    logic [DEST_W-1:0]        wr_dest;
    logic [LANES*DW-1:0]      wr_data;
    logic [LANES-1:0]         wr_mask;
    logic [2:0]               wr_src;

    modport master (
        output req_valid, req_dest, req_data, req_mask, wr_stall,
        input  req_ready, wr_valid, wr_dest, wr_data, wr_mask, wr_src
    );

    modport slave (
        input  req_valid, req_dest, req_data, req_mask, wr_stall,
        output req_ready, wr_valid, wr_dest, wr_data, wr_mask, wr_src
    );
endinterface

// File: rtl/vreg_write_arbiter.sv
// Round-robin arbiter feeding a single registered write stage for the vector register bank.
// One full-vector write is granted per cycle; the stage holds its write while the bank stalls.
module vreg_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int NREGS = 8,
    parameter int LANES = 16,
    parameter int DW    = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    vreg_write_arbiter_if.slave  bus
);
    localparam int DEST_W = $clog2(NREGS);
    localparam int SRC_W  = $clog2(NREQ);
    localparam int VW     = LANES * DW;
    localparam logic [SRC_W:0]   NREQ_EXT = (SRC_W + 1)'(NREQ);
    localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NREQ - 1);

    logic [SRC_W-1:0]  r_rrPtr;
    logic              r_wrValid;
    logic [DEST_W-1:0] r_wrDest;
    logic [VW-1:0]     r_wrData;
    logic [LANES-1:0]  r_wrMask;
    logic [2:0]        r_wrSrc;

    logic              w_canAccept;
    logic              w_found;
    logic              w_issue;
    logic [SRC_W:0]    w_scanSum;
    logic [SRC_W-1:0]  w_scanIdx;
    logic [SRC_W-1:0]  w_grantIdx;
    logic [SRC_W-1:0]  w_nextPtr;
    logic [NREQ-1:0]   w_ready;
    logic [DEST_W-1:0] w_selDest;
    logic [VW-1:0]     w_selData;
    logic [LANES-1:0]  w_selMask;

    assign w_canAccept = !r_wrValid || !bus.wr_stall;

    // Circular scan from the pointer; grants are suppressed in reset so nothing is accepted then
    always_comb begin
        w_found    = 1'b0;
        w_grantIdx = '0;
        w_scanSum  = '0;
        w_scanIdx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scanSum = {1'b0, r_rrPtr} + (SRC_W + 1)'(k);
            if (w_scanSum >= NREQ_EXT) begin
                w_scanSum = w_scanSum - NREQ_EXT;
            end
            w_scanIdx = w_scanSum[SRC_W-1:0];
            if (!w_found && bus.req_valid[w_scanIdx]) begin
                w_found    = 1'b1;
                w_grantIdx = w_scanIdx;
            end
        end
        if (!rst_n || !w_canAccept) begin
            w_found = 1'b0;
        end
    end

    always_comb begin
        w_ready   = '0;
        w_selDest = '0;
        w_selData = '0;
        w_selMask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grantIdx == SRC_W'(i)) begin
                w_ready[i] = w_found;
                w_selDest  = bus.req_dest[i*DEST_W +: DEST_W];
                w_selData  = bus.req_data[i*VW +: VW];
                w_selMask  = bus.req_mask[i*LANES +: LANES];
            end
        end
    end

    // A zero-mask winner is still handshaken but never reaches the bank
    assign w_issue   = w_found && (|w_selMask);
    assign w_nextPtr = (w_grantIdx == LAST_IDX) ? '0 : w_grantIdx + SRC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rrPtr   <= '0;
            r_wrValid <= 1'b0;
            r_wrDest  <= '0;
            r_wrData  <= '0;
            r_wrMask  <= '0;
            r_wrSrc   <= '0;
        end else begin
            if (w_found) begin
                r_rrPtr <= w_nextPtr;
            end
            if (w_canAccept) begin
                r_wrValid <= w_issue;
                if (w_issue) begin
                    r_wrDest <= w_selDest;
                    r_wrData <= w_selData;
                    r_wrMask <= w_selMask;
                    r_wrSrc  <= 3'(w_grantIdx);
                end
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.wr_valid  = r_wrValid;
    assign bus.wr_dest   = r_wrDest;
    assign bus.wr_data   = r_wrData;
    assign bus.wr_mask   = r_wrMask;
    assign bus.wr_src    = r_wrSrc;
endmodule
